// File: rtl/lh_pkg.sv
// Shared constants and types for the light-hash plaintext streamer.
// Holds the null character, ASCII bounds, default digest width and FSM states.
package lh_pkg;

    localparam logic [7:0] NULL_CHAR = 8'h00;

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [7:0] CH_UA = 8'h41;
    localparam logic [7:0] CH_UZ = 8'h5A;
    localparam logic [7:0] CH_LA = 8'h61;
    localparam logic [7:0] CH_LZ = 8'h7A;

    localparam int LH_DIGEST_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        WAIT_DIG,
        REPORT
    } lh_strm_state_t;

endpackage

// File: rtl/lh_msg_fifo.sv
// Synchronous 8-bit FIFO holding the host message before streaming.
// Ports: clk, rst, push/din (write), pop/dout (read), full, empty, count.
module lh_msg_fifo import lh_pkg::*; #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lh_ptxt_streamer.sv
// Buffers a host message, streams it to the light-hash core, checks the digest.
// Ports: host msg_* in, ptxt_* out, core digest_* in, result_valid/flags/msg_len out.
module lh_ptxt_streamer import lh_pkg::*; #(
    parameter int MSG_DEPTH = 16,
    parameter int DIGEST_W  = LH_DIGEST_W,
    parameter int TIMEOUT   = 64,
    localparam int CW = $clog2(MSG_DEPTH) + 1,
    localparam int TW = $clog2(TIMEOUT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          msg_char,
    input  logic                msg_valid,
    input  logic                msg_last,
    output logic                msg_ready,
    input  logic [DIGEST_W-1:0] exp_digest,
    output logic [7:0]          ptxt_char,
    output logic                ptxt_valid,
    input  logic [DIGEST_W-1:0] digest_char,
    input  logic                digest_ready,
    input  logic                err_invalid_ptxt_char,
    output logic                result_valid,
    output logic                match,
    output logic                err_invalid,
    output logic                err_timeout,
    output logic                truncated,
    output logic [CW-1:0]       msg_len
);

    lh_strm_state_t      state;
    lh_strm_state_t      next;
    logic [7:0]          dout;
    logic                full;
    logic                empty;
    logic [CW-1:0]       count;
    logic [TW-1:0]       tcnt;
    logic [DIGEST_W-1:0] exp_q;
    logic                pv_d;
    logic                inv_now;
    logic                push;
    logic                start;
    logic                cap;
    logic                trunc;
    logic                dig_hit;
    logic                tmo;

    lh_msg_fifo #(.DEPTH(MSG_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (ptxt_valid),
        .din   (msg_char),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign push      = msg_valid && msg_ready;
    assign ptxt_char = ptxt_valid ? dout : NULL_CHAR;
    // The core's invalid flag for the final character may land in the
    // same cycle as the digest, so fold it in before comparing.
    assign inv_now   = err_invalid || (pv_d && err_invalid_ptxt_char);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next         = state;
        msg_ready    = 1'b0;
        ptxt_valid   = 1'b0;
        result_valid = 1'b0;
        start        = 1'b0;
        cap          = 1'b0;
        trunc        = 1'b0;
        dig_hit      = 1'b0;
        tmo          = 1'b0;
        unique case (state)
            IDLE: begin
                msg_ready = !rst;
                if (msg_valid && msg_ready) begin
                    start = 1'b1;
                    if (msg_last) begin
                        cap  = 1'b1;
                        next = STREAM;
                    end else begin
                        next = LOAD;
                    end
                end
            end
            LOAD: begin
                msg_ready = !rst && !full;
                if (msg_valid && msg_ready) begin
                    if (msg_last) begin
                        cap  = 1'b1;
                        next = STREAM;
                    end else if (count == CW'(MSG_DEPTH - 1)) begin
                        cap   = 1'b1;
                        trunc = 1'b1;
                        next  = STREAM;
                    end
                end
            end
            STREAM: begin
                ptxt_valid = !empty;
                // Leave on the pop of the final character: no idle tail.
                if (count <= CW'(1)) begin
                    next = WAIT_DIG;
                end
            end
            WAIT_DIG: begin
                if (digest_ready) begin
                    dig_hit = 1'b1;
                    next    = REPORT;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    tmo  = 1'b1;
                    next = REPORT;
                end
            end
            REPORT: begin
                result_valid = 1'b1;
                next         = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt        <= '0;
            exp_q       <= '0;
            pv_d        <= 1'b0;
            match       <= 1'b0;
            err_invalid <= 1'b0;
            err_timeout <= 1'b0;
            truncated   <= 1'b0;
            msg_len     <= '0;
        end else begin
            pv_d <= ptxt_valid;
            tcnt <= (state == WAIT_DIG) ? tcnt + 1'b1 : '0;
            if (start) begin
                match       <= 1'b0;
                err_invalid <= 1'b0;
                err_timeout <= 1'b0;
                truncated   <= 1'b0;
                msg_len     <= '0;
            end
            if (cap) begin
                exp_q <= exp_digest;
            end
            if (trunc) begin
                truncated <= 1'b1;
            end
            if (ptxt_valid) begin
                msg_len <= msg_len + 1'b1;
            end
            if (pv_d && err_invalid_ptxt_char) begin
                err_invalid <= 1'b1;
            end
            if (dig_hit) begin
                match <= (digest_char == exp_q) && !inv_now;
            end
            if (tmo) begin
                err_timeout <= 1'b1;
                match       <= 1'b0;
            end
        end
    end

endmodule

// File: doc/lh_ptxt_streamer.md
Name: lh_ptxt_streamer

Overview:
- Initiator side of the light-hash plaintext interface. It buffers a host message, then drives it one character per cycle on ptxt_char/ptxt_valid into the light-hash core.
- It then waits for digest_ready, compares the returned 64-bit digest against an expected value, and reports the result.
- It sits between the host/test controller and the hash core, and is the producer and checker for that core.

Parameters:
- MSG_DEPTH, 16, maximum message length in characters; must be a power of 2 and at least 2.
- DIGEST_W, 64, width of the digest, the expected digest and the digest comparison.
- TIMEOUT, 64, maximum number of cycles to wait for digest_ready after the last streamed character.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- msg_char  in  8  host message character.
- msg_valid  in  1  host character valid.
- msg_last  in  1  marks the final character of the message; qualified by msg_valid.
- msg_ready  out  1  streamer can accept a host character this cycle.
- exp_digest  in  DIGEST_W  expected digest; sampled on the accepted msg_last beat.
- ptxt_char  out  8  character driven to the hash core.
- ptxt_valid  out  1  ptxt_char valid this cycle.
- digest_char  in  DIGEST_W  digest returned by the core.
- digest_ready  in  1  core digest valid.
- err_invalid_ptxt_char  in  1  registered invalid-character flag from the core.
- result_valid  out  1  one-cycle pulse; the result outputs below are updated on this cycle.
- match  out  1  captured digest equals the expected digest.
- err_invalid  out  1  the core flagged at least one streamed character as invalid.
- err_timeout  out  1  digest_ready did not arrive within TIMEOUT cycles.
- truncated  out  1  the message was cut at MSG_DEPTH characters.
- msg_len  out  $clog2(MSG_DEPTH)+1  number of characters streamed.

Behaviour:
- Reset (rst=1 at a clk edge) forces state IDLE, empties the buffer and clears all counters.
- Output reset values: msg_ready=0, ptxt_char=8'h00, ptxt_valid=0, result_valid=0, match=0, err_invalid=0, err_timeout=0, truncated=0, msg_len=0.
- Reset asserted in any state aborts the operation with no result pulse.

State machine: IDLE -> LOAD -> STREAM -> WAIT_DIG -> REPORT -> IDLE.
- IDLE:
  - msg_ready=1.
  - The first accepted beat writes the buffer, clears the sticky flags (match, err_invalid, err_timeout, truncated) and enters LOAD.
  - If that beat carries msg_last, the next state is STREAM directly.
- LOAD:
  - msg_ready=1 while buffer count < MSG_DEPTH.
  - An accepted beat with msg_last captures exp_digest and enters STREAM.
  - A beat that makes count == MSG_DEPTH without msg_last is treated as last: exp_digest is captured, truncated=1, msg_ready drops, and STREAM is entered.
  - Further host beats are not accepted; msg_ready stays 0 until the next IDLE.
  - A one-character message is legal.
- STREAM:
  - msg_ready=0.
  - Each cycle pops one buffered character onto ptxt_char with ptxt_valid=1; there are no bubbles.
  - After the last character, ptxt_char returns to 8'h00, ptxt_valid=0, and the state moves to WAIT_DIG.
  - msg_len counts the streamed characters.
- Invalid-character monitoring:
  - err_invalid_ptxt_char is sampled one cycle after every cycle with ptxt_valid=1; this matches the core's registered-flag latency.
  - Any 1 sets err_invalid (sticky).
  - The final sample lands in the first WAIT_DIG cycle.
- WAIT_DIG:
  - A cycle counter starts at 0.
  - digest_ready=1 captures digest_char and enters REPORT.
  - If the counter reaches TIMEOUT-1 with no digest_ready: err_timeout=1, the captured digest is treated as invalid, and the state moves to REPORT.
  - digest_ready during STREAM is ignored.
- REPORT:
  - result_valid=1 for exactly one cycle.
  - match = (captured digest == expected) && !err_timeout && !err_invalid.
  - The state then returns to IDLE.
- Result hold: match, err_invalid, err_timeout, truncated and msg_len hold their values until the next message's first accepted beat.
- Simultaneous events:
  - A WAIT_DIG cycle with both digest_ready and counter==TIMEOUT-1: the digest wins, err_timeout=0.
  - Host msg_valid outside IDLE/LOAD is not accepted (msg_ready=0).
- The buffer pointers wrap modulo MSG_DEPTH. Buffer count uses $clog2(MSG_DEPTH)+1 bits, so full and empty are unambiguous.

Decomposition:
- Package lh_pkg holds:
  - NULL_CHAR = 8'h00.
  - ASCII bound constants ('0', '9', 'A', 'Z', 'a', 'z').
  - DIGEST_W default.
  - State enum lh_strm_state_t {IDLE, LOAD, STREAM, WAIT_DIG, REPORT}.
- Sub-module lh_msg_fifo: a synchronous FIFO with width 8 and depth MSG_DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Behaviour: clears on rst.
- Top-level logic: FSM, timeout counter, sticky flags and digest compare.

Test Plan:
- Bench core model: a stub that returns digest 64'h0123_4567_89AB_CDEF with digest_ready 3 cycles after the last ptxt_valid.
- 1. Host sends "abc" with msg_last on 'c' and exp_digest=64'h0123456789ABCDEF -> ptxt_valid high exactly 3 consecutive cycles carrying 8'h61, 8'h62, 8'h63; result_valid pulses once; match=1, msg_len=3, all error flags 0.
- 2. Same message with exp_digest=64'h0 -> result_valid pulses once; match=0, err_timeout=0.
- 3. Host sends 20 chars "A".."T" with no msg_last (MSG_DEPTH=16) -> msg_ready drops after the 16th beat; 16 characters 8'h41..8'h50 are streamed; truncated=1, msg_len=16.
- 4. Stub never raises digest_ready -> result_valid pulses exactly TIMEOUT cycles after WAIT_DIG entry; err_timeout=1, match=0.
- 5. Message "a#b" with the stub asserting err_invalid_ptxt_char the cycle after '#' -> err_invalid=1, match=0 even when digests are equal.
- 6. rst asserted mid-STREAM of "xyz1" -> the next cycle shows all outputs at reset values and no result_valid; a following "abc" transaction completes as in scenario 1.
